// File: rtl/contador_cascata_pkg.sv
// Shared definitions for the cascaded modulo counter: modulo field layout,
// default modulo constants and the per-stage operation decode.
package contador_cascata_pkg;

    localparam int MOD_W        = 8;
    localparam int MAX_ESTAGIOS = 8;

    localparam int MOD_DEC = 10;
    localparam int MOD_SEX = 6;
    localparam int MOD_H24 = 24;

    typedef logic [MOD_W*MAX_ESTAGIOS-1:0] modulos_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLR   = 2'd3
    } op_t;

    // clr beats load beats en
    function automatic op_t decode_op(input logic clr, input logic load, input logic en);
        if (clr)
            return OP_CLR;
        else if (load)
            return OP_LOAD;
        else if (en)
            return OP_COUNT;
        else
            return OP_HOLD;
    endfunction

    function automatic int mod_field(input modulos_t modulos, input int idx);
        return int'(modulos[MOD_W*idx +: MOD_W]);
    endfunction

endpackage

// File: rtl/contador_cascata_if.sv
// Control/data bundle of the cascaded counter; the master drives the
// controls and load data, the slave (counter) returns counts and pulses.
interface contador_cascata_if #(
    parameter int N_ESTAGIOS = 4,
    parameter int LARGURA    = 4
);
    logic                          en;
    logic                          up;
    logic                          clr;
    logic                          load;
    logic [N_ESTAGIOS*LARGURA-1:0] load_val;
    logic [N_ESTAGIOS*LARGURA-1:0] count;
    logic [N_ESTAGIOS-1:0]         stage_wrap;
    logic                          clk_out;

    modport master (
        output en, up, clr, load, load_val,
        input  count, stage_wrap, clk_out
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, stage_wrap, clk_out
    );
endinterface

// File: rtl/contador_cascata_estagio.sv
// One modulo-MODULO up/down counter stage with clear, clamped load and a
// combinational terminal flag used to build the enable chain.
module estagio_contador
    import contador_cascata_pkg::*;
#(
    parameter int LARGURA = 4,
    parameter int MODULO  = 10
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               clr,
    input  logic               load,
    input  logic [LARGURA-1:0] load_val,
    output logic [LARGURA-1:0] count,
    output logic               term
);

    localparam logic [LARGURA-1:0] MAX_VAL = LARGURA'(MODULO - 1);

    op_t                op;
    logic [LARGURA-1:0] next_count;

    // out-of-range load data is pinned to the top of the stage's range
    function automatic logic [LARGURA-1:0] clamp(input logic [LARGURA-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign op   = decode_op(clr, load, en);
    assign term = up ? (count == MAX_VAL) : (count == '0);

    always_comb begin
        next_count = count;
        case (op)
            OP_CLR:   next_count = '0;
            OP_LOAD:  next_count = clamp(load_val);
            OP_COUNT: begin
                if (up)
                    next_count = term ? '0 : count + 1'b1;
                else
                    next_count = term ? MAX_VAL : count - 1'b1;
            end
            OP_HOLD:  next_count = count;
            default:  next_count = count;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= next_count;
    end

endmodule

// File: rtl/contador_cascata.sv
// N-stage cascaded modulo counter: all stages update on the same edge via a
// combinational enable chain; per-stage wrap flags and chain carry are registered.
module contador_cascata
    import contador_cascata_pkg::*;
#(
    parameter int                          N_ESTAGIOS = 4,
    parameter int                          LARGURA    = 4,
    parameter logic [MOD_W*N_ESTAGIOS-1:0] MODULOS    = 32'h060A_060A
) (
    input  logic                  clk_in,
    input  logic                  rst,
    contador_cascata_if.slave     bus
);

    logic [N_ESTAGIOS:0]           en_chain;
    logic [N_ESTAGIOS-1:0]         term;
    logic [LARGURA-1:0]            stage_count [N_ESTAGIOS];
    logic [N_ESTAGIOS*LARGURA-1:0] count_flat;
    logic [N_ESTAGIOS-1:0]         wrap_q;
    logic                          carry_q;

    assign en_chain[0] = bus.en;

    for (genvar i = 0; i < N_ESTAGIOS; i++) begin : g_estagio
        localparam int MOD_I = mod_field(modulos_t'(MODULOS), i);

        estagio_contador #(
            .LARGURA (LARGURA),
            .MODULO  (MOD_I)
        ) u_estagio (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en_chain[i]),
            .up       (bus.up),
            .clr      (bus.clr),
            .load     (bus.load),
            .load_val (bus.load_val[LARGURA*i +: LARGURA]),
            .count    (stage_count[i]),
            .term     (term[i])
        );

        // a stage advances only when every lower stage sits at its terminal value
        assign en_chain[i+1] = en_chain[i] & term[i];
    end

    always_comb begin
        count_flat = '0;
        for (int i = 0; i < N_ESTAGIOS; i++)
            count_flat[LARGURA*i +: LARGURA] = stage_count[i];
    end

    // en_chain[i+1] is exactly "stage i enabled and terminal", i.e. it wraps this edge
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wrap_q  <= '0;
            carry_q <= 1'b0;
        end else if (bus.clr || bus.load) begin
            wrap_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            wrap_q  <= en_chain[N_ESTAGIOS:1];
            carry_q <= en_chain[N_ESTAGIOS];
        end
    end

    assign bus.count      = count_flat;
    assign bus.stage_wrap = wrap_q;
    assign bus.clk_out    = carry_q;

endmodule
